to_lower_stream: RTL and testbench

- Streaming 8-bit character case converter, the inverse of the existing upper-case converter.
- Maps upper-case ASCII 'A'..'Z' (65..90) to lower-case 'a'..'z' (97..122); all other codes pass unchanged.
- Sits between a byte source and a byte sink, with valid/ready handshakes on both sides, a 1-cycle registered output, a skid buffer for full throughput, and saturating statistics counters.

---
 rtl/to_lower_pkg.sv | 20 ++
 rtl/to_lower_stream_char_case_map.sv | 24 ++
 rtl/to_lower_stream.sv | 114 +++++++++++
 tb/tb_to_lower_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/to_lower_pkg.sv
// Shared constants and types for the to_lower_stream case converter.
// The TO_LOWER_LATIN1_EN macro (when defined) enables Latin-1 upper-case
// folding in char_case_map; the constants below serve both builds.
package to_lower_pkg;

   typedef logic [7:0] char_t;

   localparam char_t ASCII_UP_LO  = 8'd65;
   localparam char_t ASCII_UP_HI  = 8'd90;
   localparam char_t CASE_OFFSET  = 8'd32;
   localparam char_t LATIN1_UP_LO = 8'd192;
   localparam char_t LATIN1_UP_HI = 8'd222;
   localparam char_t LATIN1_MUL   = 8'd215;

   // Inclusive range test used by the case mapper.
   function automatic logic in_range(input char_t c, input char_t lo, input char_t hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/to_lower_stream_char_case_map.sv
// Combinational upper-to-lower case mapper for one 8-bit character.
// Macro TO_LOWER_LATIN1_EN: also fold Latin-1 upper case 192..222 except 215.
// Both mapped ranges have bit 5 clear, so "+32" is a plain bit-5 set.
module char_case_map
   import to_lower_pkg::*;
(
   input  char_t in_char,
   output char_t out_char,
   output logic  changed
);

   // Decide whether the character is upper case, then set bit 5 if so.
   always_comb begin
      changed = in_range(in_char, ASCII_UP_LO, ASCII_UP_HI);
`ifdef TO_LOWER_LATIN1_EN
      if (in_range(in_char, LATIN1_UP_LO, LATIN1_UP_HI) && (in_char != LATIN1_MUL))
         changed = 1'b1;
`else
      changed = changed;
`endif
      out_char = changed ? (in_char | CASE_OFFSET) : in_char;
   end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming lower-case converter with valid/ready on both sides, a registered
// output stage plus a one-entry skid buffer, and saturating statistics.
// Optional Latin-1 folding is selected by macro TO_LOWER_LATIN1_EN (see
// char_case_map).
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | output register empty, skid empty (out_valid=0)
// ONE   | output register holds a char, skid empty
// FULL  | output register and skid both hold a char, input stalled
module to_lower_stream
   import to_lower_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] char_cnt,
   output logic [CNT_W-1:0] conv_cnt
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0] state;
   char_t      out_reg;
   logic       out_chg;
   char_t      skid_reg;
   logic       skid_chg;

   char_t      map_char;
   logic       map_chg;
   logic       accept;
   logic       xfer;

   char_case_map u_map (
      .in_char  (in_data),
      .out_char (map_char),
      .changed  (map_chg)
   );

   // Ready depends only on registered state, never on out_ready.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = out_reg;
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   // Storage state machine: output register plus one-entry skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_reg  <= '0;
         out_chg  <= 1'b0;
         skid_reg <= '0;
         skid_chg <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  out_reg <= map_char;
                  out_chg <= map_chg;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  out_reg <= map_char;
                  out_chg <= map_chg;
               end else if (accept) begin
                  skid_reg <= map_char;
                  skid_chg <= map_chg;
                  state    <= FULL;
               end else if (xfer) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (xfer) begin
                  out_reg <= skid_reg;
                  out_chg <= skid_chg;
                  state   <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Saturating counters of delivered and converted characters; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_cnt <= '0;
         conv_cnt <= '0;
      end else if (clr_cnt) begin
         char_cnt <= '0;
         conv_cnt <= '0;
      end else if (xfer) begin
         if (char_cnt != '1)
            char_cnt <= char_cnt + CNT_W'(1);
         if (out_chg && (conv_cnt != '1))
            conv_cnt <= conv_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_to_lower_stream.sv
// Directed self-checking bench for to_lower_stream (counters built 4 bits wide
// so saturation is reachable quickly).
module tb_to_lower_stream;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic          clr_cnt;
   logic [CW-1:0] char_cnt;
   logic [CW-1:0] conv_cnt;

   int errors = 0;
   int checks = 0;

   to_lower_stream #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .clr_cnt   (clr_cnt),
      .char_cnt  (char_cnt),
      .conv_cnt  (conv_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref_lower(input logic [7:0] c);
      if (c > 8'd64 && c < 8'd91) return c + 8'd32;
`ifdef TO_LOWER_LATIN1_EN
      if (c > 8'd191 && c < 8'd223 && c != 8'd215) return c + 8'd32;
`endif
      return c;
   endfunction

   logic [7:0] tp_in  [8] = '{8'd40, 8'd72, 8'd97, 8'd65, 8'd122, 8'd64, 8'd91, 8'd90};
   logic [7:0] tp_out [8] = '{8'd40, 8'd104, 8'd97, 8'd97, 8'd122, 8'd64, 8'd91, 8'd122};
   logic [7:0] l1_in  [4] = '{8'd207, 8'd215, 8'd222, 8'd235};
`ifdef TO_LOWER_LATIN1_EN
   logic [7:0] l1_out [4] = '{8'd239, 8'd215, 8'd254, 8'd235};
   localparam int L1_CONV = 2;
`else
   logic [7:0] l1_out [4] = '{8'd207, 8'd215, 8'd222, 8'd235};
   localparam int L1_CONV = 0;
`endif

   logic [7:0] sb [$];
   logic [7:0] exp_c;
   logic [7:0] held;
   logic       stalled;
   int         sent;
   int         got;
   int         cyc;
   int         conv0;

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_char_cnt", int'(char_cnt), 0);
      chk("rst_conv_cnt", int'(conv_cnt), 0);
      tick();

      // Full-throughput mapping, no bubbles.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = tp_in[i]; in_valid = 1'b1;
         chk("tp_in_ready", int'(in_ready), 1);
         if (i > 0) begin
            chk("tp_out_valid", int'(out_valid), 1);
            chk("tp_out_data", int'(out_data), int'(tp_out[i-1]));
         end
         tick();
      end
      in_valid = 1'b0;
      chk("tp_last_valid", int'(out_valid), 1);
      chk("tp_last_data", int'(out_data), int'(tp_out[7]));
      tick();
      chk("tp_drained", int'(out_valid), 0);
      chk("tp_char_cnt", int'(char_cnt), 8);
      chk("tp_conv_cnt", int'(conv_cnt), 3);

      // Backpressure and skid.
      out_ready = 1'b0;
      in_data = 8'd65; in_valid = 1'b1;
      chk("bp_ready_a", int'(in_ready), 1);
      tick();
      in_data = 8'd66;
      chk("bp_ready_b", int'(in_ready), 1);
      chk("bp_data_a", int'(out_data), 97);
      tick();
      in_data = 8'd67;
      chk("bp_ready_full", int'(in_ready), 0);
      chk("bp_hold_a", int'(out_data), 97);
      tick();
      chk("bp_still_full", int'(in_ready), 0);
      chk("bp_hold_a2", int'(out_data), 97);
      out_ready = 1'b1;
      tick();
      chk("bp_data_b", int'(out_data), 98);
      chk("bp_ready_c", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("bp_data_c", int'(out_data), 99);
      chk("bp_valid_c", int'(out_valid), 1);
      tick();
      chk("bp_drained", int'(out_valid), 0);
      chk("bp_char_cnt", int'(char_cnt), 11);
      chk("bp_conv_cnt", int'(conv_cnt), 6);

      // Saturation with 20 'Z'.
      for (int i = 0; i < 20; i++) begin
         in_data = 8'd90; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      chk("sat_char_cnt", int'(char_cnt), 15);
      chk("sat_conv_cnt", int'(conv_cnt), 15);

      // Clear coincident with a transfer.
      in_data = 8'd90; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; clr_cnt = 1'b1;
      chk("clr_xfer_valid", int'(out_valid), 1);
      tick();
      clr_cnt = 1'b0;
      chk("clr_char_cnt", int'(char_cnt), 0);
      chk("clr_conv_cnt", int'(conv_cnt), 0);
      in_data = 8'd81; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("post_clr_char", int'(char_cnt), 1);
      chk("post_clr_conv", int'(conv_cnt), 1);

      // Latin-1 range.
      conv0 = int'(conv_cnt);
      for (int i = 0; i < 4; i++) begin
         in_data = l1_in[i]; in_valid = 1'b1;
         if (i > 0) chk("l1_data", int'(out_data), int'(l1_out[i-1]));
         tick();
      end
      in_valid = 1'b0;
      chk("l1_data_last", int'(out_data), int'(l1_out[3]));
      tick();
      chk("l1_conv_cnt", int'(conv_cnt), conv0 + L1_CONV);

      // Random handshake against a reference model and FIFO scoreboard.
      sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
      while ((sent < 1000 || got < 1000) && cyc < 20000) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 2) != 0);
         if (stalled) chk("rnd_stable", int'(out_data), int'(held));
         if (in_valid && in_ready) begin
            sb.push_back(ref_lower(in_data));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rnd_spurious", 1, 0);
            end else begin
               exp_c = sb.pop_front();
               chk("rnd_data", int'(out_data), int'(exp_c));
            end
            got++;
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      chk("rnd_timeout", int'(cyc < 20000), 1);
      chk("rnd_sb_empty", sb.size(), 0);
      chk("rnd_out_idle", int'(out_valid), 0);
      chk("rnd_char_sat", int'(char_cnt), 15);

      // Mid-stream reset with output and skid both occupied.
      out_ready = 1'b0;
      in_data = 8'd70; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      chk("mr_pre_full", int'(in_ready), 0);
      chk("mr_pre_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid_now", int'(out_valid), 0);
      chk("mr_char_now", int'(char_cnt), 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mr_in_ready", int'(in_ready), 1);
      chk("mr_out_valid", int'(out_valid), 0);
      chk("mr_conv_cnt", int'(conv_cnt), 0);
      out_ready = 1'b1;
      tick();
      chk("mr_no_stale", int'(out_valid), 0);
      chk("mr_char_after", int'(char_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
